// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single memory port between icache and dcache; data side has priority.
// Optional instruction-side anti-starvation counter is enabled with `define ARB_FAIRNESS_EN.
module cache_mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [DATA_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              dwait,
   output logic [DATA_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic              ram_ready,
   output logic              gnt_d
);

   typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;
   state_t state;

   logic d_req;
   assign d_req = dREN | dWEN;

`ifdef ARB_FAIRNESS_EN
   localparam int CNT_W = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
   logic [CNT_W-1:0] starve_cnt;
   logic             force_i;
   assign force_i = iREN && (starve_cnt == CNT_W'(STARVE_MAX));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= IDLE;
         starve_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (force_i)     state <= IGNT;
               else if (d_req)  state <= DGNT;
               else if (iREN)   state <= IGNT;
               if (!iREN) starve_cnt <= '0;
            end
            DGNT: begin
               // Only a completed data access while I waits counts as starvation.
               if (d_req && ram_ready && iREN && starve_cnt != CNT_W'(STARVE_MAX))
                  starve_cnt <= starve_cnt + 1'b1;
               if (!d_req || ram_ready) state <= IDLE;
            end
            IGNT: begin
               if (iREN && ram_ready) starve_cnt <= '0;
               if (!iREN || ram_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   logic unused_starve_max;
   assign unused_starve_max = |STARVE_MAX;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (d_req)      state <= DGNT;
               else if (iREN)  state <= IGNT;
            end
            DGNT:    if (!d_req || ram_ready) state <= IDLE;
            IGNT:    if (!iREN || ram_ready)  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
`endif

   // A withdrawn request drops the strobes at once and suppresses the wait pulse.
   always_comb begin
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      gnt_d    = 1'b0;
      case (state)
         DGNT: begin
            gnt_d    = 1'b1;
            ramaddr  = daddr;
            ramstore = dstore;
            dload    = ramload;
            if (d_req) begin
               ramWEN = dWEN;
               ramREN = dREN & ~dWEN;
               dwait  = ~ram_ready;
            end
         end
         IGNT: begin
            ramaddr = iaddr;
            iload   = ramload;
            if (iREN) begin
               ramREN = 1'b1;
               iwait  = ~ram_ready;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed cases, fairness/starvation run,
// and a randomized run checked every cycle against a behavioural ownership model.
module tb_cache_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SM = 4;
   localparam int OWN_NONE = 0;
   localparam int OWN_I    = 1;
   localparam int OWN_D    = 2;

   logic          CLK = 1'b0;
   logic          nRST;
   logic          iREN, dREN, dWEN, ram_ready;
   logic [AW-1:0] iaddr, daddr, ramaddr;
   logic [DW-1:0] dstore, ramload, iload, dload, ramstore;
   logic          iwait, dwait, ramREN, ramWEN, gnt_d;

   int n_vec = 0;
   int n_bad = 0;

   cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ram_ready(ram_ready), .gnt_d(gnt_d)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Behavioural model: who owns the port, and how many D completions I has watched.
   int owner  = OWN_NONE;
   int starve = 0;

   always @(negedge CLK) begin : monitor
      logic dreq;
      logic e_iwait, e_dwait, e_ren, e_wen, e_gnt;
      if (!nRST) begin
         owner  = OWN_NONE;
         starve = 0;
      end
      dreq    = dREN | dWEN;
      e_iwait = 1'b1; e_dwait = 1'b1; e_ren = 1'b0; e_wen = 1'b0; e_gnt = 1'b0;
      if (owner == OWN_D) begin
         e_gnt = 1'b1;
         if (dreq) begin
            e_wen   = dWEN;
            e_ren   = !dWEN;
            e_dwait = !ram_ready;
         end
      end else if (owner == OWN_I && iREN) begin
         e_ren   = 1'b1;
         e_iwait = !ram_ready;
      end
      chk("m_iwait", iwait, e_iwait);
      chk("m_dwait", dwait, e_dwait);
      chk("m_ramREN", ramREN, e_ren);
      chk("m_ramWEN", ramWEN, e_wen);
      chk("m_gnt_d", gnt_d, e_gnt);
      if (owner == OWN_NONE) begin
         chk("m_idle_addr", ramaddr, 0);
         chk("m_idle_store", ramstore, 0);
         chk("m_idle_iload", iload, 0);
         chk("m_idle_dload", dload, 0);
      end else begin
         if (e_ren || e_wen) chk("m_ramaddr", ramaddr, (owner == OWN_I) ? iaddr : daddr);
         if (e_wen) chk("m_ramstore", ramstore, dstore);
         if (!e_iwait) chk("m_iload", iload, ramload);
         if (!e_dwait) chk("m_dload", dload, ramload);
      end
      if (nRST) begin
         case (owner)
            OWN_NONE: begin
`ifdef ARB_FAIRNESS_EN
               if (iREN && starve == SM) owner = OWN_I;
               else
`endif
               if (dreq) owner = OWN_D;
               else if (iREN) owner = OWN_I;
               if (!iREN) starve = 0;
            end
            OWN_D: begin
               if (dreq && ram_ready && iREN && starve < SM) starve++;
               if (!dreq || ram_ready) owner = OWN_NONE;
            end
            default: begin
               if (iREN && ram_ready) starve = 0;
               if (!iREN || ram_ready) owner = OWN_NONE;
            end
         endcase
      end
   end

   task automatic clear_inputs();
      iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
      iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
   endtask

   task automatic reset_pulse();
      nRST = 0;
      step();
      step();
      nRST = 1;
   endtask

   initial begin : main
      logic [7:0] exp_q[$];
      logic [7:0] got_q[$];
      int budget;
      bit  i_done, d_done;
      clear_inputs();
      reset_pulse();

      chk("rst_iwait", iwait, 1);
      chk("rst_dwait", dwait, 1);
      chk("rst_ramREN", ramREN, 0);
      chk("rst_ramWEN", ramWEN, 0);
      chk("rst_ramaddr", ramaddr, 0);
      chk("rst_gnt_d", gnt_d, 0);

      // Plain instruction fetch.
      iREN = 1; iaddr = 32'h100;
      step(); #1;
      chk("i_ramREN", ramREN, 1);
      chk("i_ramaddr", ramaddr, 32'h100);
      chk("i_wait_hold", iwait, 1);
      ram_ready = 1; ramload = 32'hDEADBEEF; #1;
      chk("i_wait_low", iwait, 0);
      chk("i_iload", iload, 32'hDEADBEEF);
      step(); iREN = 0; ram_ready = 0; #1;
      chk("i_back_idle_wait", iwait, 1);
      chk("i_back_idle_ren", ramREN, 0);

      // Data write beats a waiting instruction read, then I goes.
      iREN = 1; iaddr = 32'h104; dWEN = 1; daddr = 32'h200; dstore = 32'h12345678;
      step(); #1;
      chk("dw_gnt_d", gnt_d, 1);
      chk("dw_ramWEN", ramWEN, 1);
      chk("dw_ramREN", ramREN, 0);
      chk("dw_ramaddr", ramaddr, 32'h200);
      chk("dw_ramstore", ramstore, 32'h12345678);
      chk("dw_iwait", iwait, 1);
      ram_ready = 1; #1;
      chk("dw_dwait_low", dwait, 0);
      step(); dWEN = 0; ram_ready = 0; #1;
      chk("dw_bubble_gnt", gnt_d, 0);
      chk("dw_bubble_ren", ramREN, 0);
      step(); #1;
      chk("dw_then_i_ren", ramREN, 1);
      chk("dw_then_i_addr", ramaddr, 32'h104);
      ram_ready = 1; ramload = 32'hCAFE0001; #1;
      chk("dw_then_i_wait", iwait, 0);
      chk("dw_then_i_load", iload, 32'hCAFE0001);
      step(); iREN = 0; ram_ready = 0;

      // Read and write together: write wins.
      dREN = 1; dWEN = 1; daddr = 32'h300; dstore = 32'hA5A5A5A5;
      step(); #1;
      chk("rw_ramWEN", ramWEN, 1);
      chk("rw_ramREN", ramREN, 0);
      ram_ready = 1;
      step(); dREN = 0; dWEN = 0; ram_ready = 0;

      // Data read.
      dREN = 1; daddr = 32'h400;
      step(); #1;
      chk("dr_ramREN", ramREN, 1);
      chk("dr_ramWEN", ramWEN, 0);
      ram_ready = 1; ramload = 32'h0BADF00D; #1;
      chk("dr_dwait", dwait, 0);
      chk("dr_dload", dload, 32'h0BADF00D);
      step(); dREN = 0; ram_ready = 0;

      // Instruction withdraws in the same cycle ram_ready arrives.
      iREN = 1; iaddr = 32'h500;
      step(); iREN = 0; ram_ready = 1; #1;
      chk("wd_ramREN", ramREN, 0);
      chk("wd_iwait", iwait, 1);
      step(); ram_ready = 0; #1;
      chk("wd_idle_ren", ramREN, 0);
      chk("wd_idle_gnt", gnt_d, 0);

      // Asynchronous reset in the middle of a data grant.
      dREN = 1; daddr = 32'h600;
      step(); #1;
      chk("ar_gnt_before", gnt_d, 1);
      nRST = 0; #1;
      chk("ar_ramREN", ramREN, 0);
      chk("ar_gnt_d", gnt_d, 0);
      chk("ar_dwait", dwait, 1);
      dREN = 0;
      step(); nRST = 1;

      // Continuous D and I traffic with ram_ready always high.
      reset_pulse();
      dREN = 1; iREN = 1; ram_ready = 1; daddr = 32'h700; iaddr = 32'h800;
      for (int k = 0; k < 50; k++) begin
`ifdef ARB_FAIRNESS_EN
         exp_q.push_back((k % 5 == 4) ? "I" : "D");
`else
         exp_q.push_back("D");
`endif
      end
      budget = 400;
      while (got_q.size() < 50 && budget > 0) begin
         @(negedge CLK); #1;
         if (!iwait) got_q.push_back("I");
         if (!dwait) got_q.push_back("D");
         budget--;
      end
      chk("fair_count", got_q.size(), 50);
      for (int k = 0; k < 50 && k < got_q.size(); k++)
         chk($sformatf("fair_order_%0d", k), got_q[k], exp_q[k]);
      step(); clear_inputs();
      reset_pulse();

      // Randomized traffic, checked cycle by cycle by the monitor.
      for (int c = 0; c < 2000; c++) begin
         i_done = !iwait;
         d_done = !dwait;
         step();
         ram_ready = ($urandom_range(0, 2) == 0);
         ramload   = $urandom;
         if (iREN && (i_done || $urandom_range(0, 15) == 0)) iREN = 0;
         else if (!iREN && $urandom_range(0, 2) == 0) begin
            iREN = 1; iaddr = $urandom;
         end
         if ((dREN || dWEN) && (d_done || $urandom_range(0, 15) == 0)) begin
            dREN = 0; dWEN = 0;
         end else if (!(dREN || dWEN) && $urandom_range(0, 2) == 0) begin
            dREN = $urandom_range(0, 1); dWEN = $urandom_range(0, 1);
            if (!dREN && !dWEN) dREN = 1;
            daddr = $urandom; dstore = $urandom;
         end
         if ($urandom_range(0, 199) == 0) begin
            #2 nRST = 0;
            step(); nRST = 1;
         end
      end

      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single memory port between the instruction cache and the data cache.
- Sits between the cache block (icache + dcache) and the memory/RAM model.
- Registers one grant at a time and holds it until the memory signals completion.
- Data requests have priority; instruction requests are protected from starvation by an optional fairness counter.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data word width.
- STARVE_MAX, 4, consecutive D grants allowed while an I request waits (fairness feature only).

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  icache read request, held until iwait falls
- iaddr  in  ADDR_W  icache address
- iwait  out  1  low for exactly one cycle when the icache read completes
- iload  out  DATA_W  icache read data, valid when iwait low
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  ADDR_W  dcache address
- dstore  in  DATA_W  dcache write data
- dwait  out  1  low for exactly one cycle when the dcache access completes
- dload  out  DATA_W  dcache read data, valid when dwait low
- ramREN  out  1  memory read strobe
- ramWEN  out  1  memory write strobe
- ramaddr  out  ADDR_W  memory address
- ramstore  out  DATA_W  memory write data
- ramload  in  DATA_W  memory read data
- ram_ready  in  1  one-cycle pulse: current access complete
- gnt_d  out  1  debug: data side holds grant

Behaviour:
- One clock (CLK), asynchronous active-low reset (nRST).
- FSM states: IDLE, IGNT, DGNT. Reset state is IDLE.
- Reset values, and values in IDLE: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0, gnt_d=0.
- IDLE transitions:
  - (dREN|dWEN) -> DGNT
  - else iREN -> IGNT
  - else stay in IDLE.
- DGNT:
  - ramaddr=daddr, ramstore=dstore.
  - If dWEN: ramWEN=1, ramREN=0. A write wins when dREN and dWEN are both high.
  - Else: ramREN=dREN.
  - gnt_d=1.
  - dwait = ~ram_ready; dload = ramload.
  - On ram_ready -> IDLE.
- IGNT:
  - ramaddr=iaddr, ramREN=1; iwait = ~ram_ready; iload = ramload.
  - On ram_ready -> IDLE.
- Outputs are combinational from state and the granted requester; the non-granted side's wait stays 1.
- Latency: request seen in IDLE at cycle N -> grant state at N+1 -> earliest completion (ram_ready) at N+1. Minimum 2 cycles per access, with one IDLE bubble between accesses.
- Withdrawal: if the granted requester drops its request before ram_ready, strobes deassert that cycle and FSM -> IDLE. A ram_ready in that same cycle is ignored; no wait pulse is produced.
- Simultaneous iREN and dREN/dWEN in IDLE: D wins (unless fairness forces I).
- ram_ready while in IDLE: ignored.
- Reset asserted mid-access: immediate return to IDLE; strobes drop asynchronously; the fairness counter clears.
- Grant never changes while ram_ready is low and the request is held; no preemption.

Optional Feature:
- Macro: ARB_FAIRNESS_EN.
- With the macro: a 3-bit-or-wider counter starve_cnt increments on each DGNT completion while iREN=1, saturating at STARVE_MAX.
  - It clears on IGNT completion or when iREN=0 in IDLE.
  - In IDLE with starve_cnt==STARVE_MAX and iREN=1, the arbiter goes to IGNT even if a D request is present.
- Without the macro: strict D priority, no counter, I may starve indefinitely.

Test Plan:
- Reset, then iREN=1, iaddr=0x100, ram_ready one cycle after grant, ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x100 in IGNT; iwait low exactly 1 cycle with iload=0xDEADBEEF; FSM back to IDLE.
- dWEN=1, daddr=0x200, dstore=0x12345678, with iREN=1 held -> DGNT first, ramWEN=1, ramstore=0x12345678; IGNT only after dwait pulses.
- dREN=1 and dWEN=1 together -> ramWEN=1, ramREN=0.
- Mid-access: iREN drops before ram_ready; then nRST pulsed low in a later DGNT -> strobes go 0, no wait pulse, FSM in IDLE.
- With ARB_FAIRNESS_EN, STARVE_MAX=4, dREN continuous, iREN continuous -> 4 D completions, then 1 I completion, repeating.
- Without ARB_FAIRNESS_EN, same stimulus -> iwait never falls over 50 accesses.
